// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with full-scan debounce.
// Emits one is_pressed_next pulse per accepted press; releases are debounced too.
module keypad_scanner #(
    parameter int SCAN_DIV       = 2500,
    parameter int DEBOUNCE_SCANS = 100
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] button,
    output logic       is_pressed_next,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        ACCEPT   = 3'd2,
        HELD     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      scan_bits_s;
    logic [4:0]       hits_s;
    logic [3:0]       hit_code_s;
    logic             sample_s, scan_end_s, scan_none_s, scan_single_s;

    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;

    logic [3:0]       button_q, button_d;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Column timing and per-column sampling into the scan image.
    always_comb begin
        sample_s   = (div_q == DIV_LAST);
        scan_end_s = sample_s && (col_idx_q == 2'd3);
        div_d      = sample_s ? {DIV_W{1'b0}} : (div_q + DIV_W'(1));
        col_idx_d  = sample_s ? (col_idx_q + 2'd1) : col_idx_q;
        col_d      = ~(4'b0001 << col_idx_d);
        scan_bits_s = acc_q;
        for (int r = 0; r < 4; r++) begin
            scan_bits_s[{2'(r), col_idx_q}] = ~row_sync_q[r];
        end
        acc_d = sample_s ? scan_bits_s : acc_q;
    end

    // Classify the completed scan image; bit index equals the key code {row, col}.
    always_comb begin
        hits_s     = 5'd0;
        hit_code_s = 4'd0;
        for (int i = 0; i < 16; i++) begin
            hits_s     = hits_s + {4'd0, scan_bits_s[i]};
            hit_code_s = hit_code_s | (scan_bits_s[i] ? 4'(i) : 4'd0);
        end
        scan_none_s   = (hits_s == 5'd0);
        scan_single_s = (hits_s == 5'd1);
    end

    // Scan timing registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= {DIV_W{1'b0}};
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            acc_q     <= 16'h0000;
        end else begin
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            acc_q     <= acc_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic; only ACCEPT advances outside a scan end.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        cnt_inc_s = (cnt_q >= CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        case (state_q)
            IDLE: begin
                if (scan_end_s && scan_single_s) begin
                    cand_d  = hit_code_s;
                    cnt_d   = CNT_ONE;
                    state_d = (DEBOUNCE_SCANS == 1) ? ACCEPT : DEBOUNCE;
                end else begin
                    state_d = IDLE;
                end
            end
            DEBOUNCE: begin
                if (!scan_end_s) begin
                    state_d = DEBOUNCE;
                end else if (scan_single_s && (hit_code_s == cand_q)) begin
                    cnt_d   = cnt_inc_s;
                    state_d = (cnt_inc_s == CNT_MAX) ? ACCEPT : DEBOUNCE;
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end
            end
            ACCEPT: begin
                state_d = HELD;
            end
            HELD: begin
                if (scan_end_s && scan_none_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                end else begin
                    state_d = HELD;
                end
            end
            RELEASE: begin
                if (!scan_end_s) begin
                    state_d = RELEASE;
                end else if (scan_none_s) begin
                    cnt_d   = cnt_inc_s;
                    state_d = (cnt_inc_s == CNT_MAX) ? IDLE : RELEASE;
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = HELD;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase
    end

    // Output next values, derived from the transition being taken.
    always_comb begin
        button_d = button_q;
        pulse_d  = 1'b0;
        held_d   = held_q;
        if (state_d == ACCEPT) begin
            button_d = cand_d;
            pulse_d  = 1'b1;
            held_d   = 1'b1;
        end else if ((state_d == IDLE) && ((state_q == HELD) || (state_q == RELEASE))) begin
            held_d = 1'b0;
        end else begin
            held_d = held_q;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            button_q <= 4'd0;
            pulse_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            button_q <= button_d;
            pulse_q  <= pulse_d;
            held_q   <= held_d;
        end
    end

    assign col             = col_q;
    assign button          = button_q;
    assign is_pressed_next = pulse_q;
    assign key_held        = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad matrix model.
// Key changes are applied on scan boundaries (16 clocks per scan).
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  row, col, button;
    logic        is_pressed_next, key_held;
    logic [15:0] keys;

    int tests = 0, fails = 0;
    int pulses = 0, last_pulse = 0, tcount = 0, viol = 0;
    logic       prev_pulse, prev_rst;
    logic [3:0] prev_button;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .row             (row),
        .col             (col),
        .button          (button),
        .is_pressed_next (is_pressed_next),
        .key_held        (key_held)
    );

    always #5 clock = ~clock;

    // Keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        tcount++;
        if (reset_n && prev_rst) begin
            if (is_pressed_next && prev_pulse) viol++;
            if ((button !== prev_button) && !is_pressed_next) viol++;
        end
        if (is_pressed_next) begin
            pulses++;
            last_pulse = tcount;
        end
        prev_pulse  = is_pressed_next;
        prev_button = button;
        prev_rst    = reset_n;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic win();
        pulses     = 0;
        tcount     = 0;
        last_pulse = 0;
    endtask

    initial begin
        keys        = 16'h0000;
        reset_n     = 1'b0;
        prev_rst    = 1'b0;
        prev_pulse  = 1'b0;
        prev_button = 4'd0;
        ticks(3);
        check("rst_col",    col,             4'hE);
        check("rst_button", button,          4'h0);
        check("rst_pulse",  is_pressed_next, 1'b0);
        check("rst_held",   key_held,        1'b0);
        reset_n = 1'b1;

        // Key row2/col1 held for 6 scans, then released.
        keys = 16'h0200;
        win();
        ticks(96);
        check("t2_pulses",     pulses,     1);
        check("t2_pulse_time", last_pulse, 48);
        check("t2_button",     button,     4'h9);
        check("t2_held",       key_held,   1'b1);
        keys = 16'h0000;
        win();
        ticks(47);
        check("t2_held_rel2", key_held, 1'b1);
        tick();
        check("t2_held_rel3", key_held, 1'b0);
        check("t2_no_repeat", pulses,   0);

        // Bounce: present, absent, then stable on row0/col2.
        keys = 16'h0004;
        win();
        ticks(16);
        keys = 16'h0000;
        ticks(16);
        keys = 16'h0004;
        ticks(47);
        check("t3_early", pulses, 0);
        tick();
        check("t3_pulse",  is_pressed_next, 1'b1);
        check("t3_button", button,          4'h2);
        ticks(16);
        check("t3_single", pulses, 1);
        keys = 16'h0000;
        ticks(64);

        // Two keys at once: invalid scans, no event.
        keys = 16'h4001;
        win();
        ticks(160);
        check("t4_pulses", pulses,   0);
        check("t4_button", button,   4'h2);
        check("t4_held",   key_held, 1'b0);
        keys = 16'h0000;
        ticks(16);

        // Release glitches while held.
        keys = 16'h0020;
        win();
        ticks(64);
        check("t5_press",  pulses, 1);
        check("t5_button", button, 4'h5);
        win();
        keys = 16'h0000;
        ticks(16);
        keys = 16'h0020;
        ticks(16);
        keys = 16'h0000;
        ticks(32);
        check("t5_held_gl", key_held, 1'b1);
        keys = 16'h0020;
        ticks(16);
        check("t5_no_event", pulses,   0);
        check("t5_held_gl2", key_held, 1'b1);
        keys = 16'h0000;
        ticks(48);
        check("t5_released", key_held, 1'b0);
        keys = 16'h0080;
        win();
        ticks(64);
        check("t5_pulses2", pulses,   1);
        check("t5_button2", button,   4'h7);
        check("t5_held2",   key_held, 1'b1);

        // Asynchronous reset in the middle of a column period.
        ticks(5);
        #2;
        reset_n = 1'b0;
        #1;
        check("t1_col",    col,             4'hE);
        check("t1_button", button,          4'h0);
        check("t1_pulse",  is_pressed_next, 1'b0);
        check("t1_held",   key_held,        1'b0);
        keys = 16'h0000;
        ticks(2);
        reset_n = 1'b1;

        // Reset during debounce discards progress.
        keys = 16'h0400;
        win();
        ticks(32);
        check("t6_pre", pulses, 0);
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        ticks(47);
        check("t6_early", pulses, 0);
        tick();
        check("t6_pulse",  is_pressed_next, 1'b1);
        check("t6_button", button,          4'hA);
        check("t6_held",   key_held,        1'b1);
        ticks(16);

        check("monitor_pulse_button", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
